// File: rtl/counter_74x163.sv
// Synchronous 4-bit-style binary counter modelled on the 74x163: clear, load, count, hold.
// Define COUNTER_74X163_SYNC_EN to pass the control inputs through 2-flop synchronizers.
module counter_74x163 #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR_N,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam logic [3:0] CTL_IDLE = 4'b1100;  // {CLR_N, LOAD_N, ENP, ENT} all inactive

  logic             clr_n_eff;
  logic             load_n_eff;
  logic             enp_eff;
  logic             ent_eff;
  logic [WIDTH-1:0] count_p0;

  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             clr_n,
    input logic             load_n,
    input logic             enp,
    input logic             ent
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    if (!clr_n)          nxt = '0;
    else if (!load_n)    nxt = din;
    else if (enp && ent) nxt = cur + WIDTH'(1);  // natural wrap, no saturation
    return nxt;
  endfunction

`ifdef COUNTER_74X163_SYNC_EN
  logic [3:0] ctl_p0;
  logic [3:0] ctl_p1;

  // Synchronizer stages: raw pins -> ctl_p0 -> ctl_p1
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctl_p0 <= CTL_IDLE;
      ctl_p1 <= CTL_IDLE;
    end else begin
      ctl_p0 <= {CLR_N, LOAD_N, ENP, ENT};
      ctl_p1 <= ctl_p0;
    end
  end

  assign {clr_n_eff, load_n_eff, enp_eff, ent_eff} = ctl_p1;
`else
  assign {clr_n_eff, load_n_eff, enp_eff, ent_eff} = {CLR_N, LOAD_N, ENP, ENT};
`endif

  // Count register stage
  always_ff @(posedge CLK) begin
    if (RST) count_p0 <= '0;
    else     count_p0 <= next_count(count_p0, D, clr_n_eff, load_n_eff, enp_eff, ent_eff);
  end

  assign Q   = count_p0;
  assign RCO = ent_eff && (count_p0 == {WIDTH{1'b1}});

endmodule

// File: tb/tb_counter_74x163.sv
// Directed bench for counter_74x163: vector table plus reset, cascade and synchronizer sequences.
module tb_counter_74x163;

  logic       clk;
  logic       rst;
  logic       clr_n;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic [3:0] d;
  logic [3:0] q_lo;
  logic [3:0] q_hi;
  logic       rco_lo;
  logic       rco_hi;
  logic [3:0] d_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       clr_n;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [3:0] d;
    logic [3:0] exp_q;
    logic       exp_rco;
  } vec_t;

  vec_t vecs[$];

  counter_74x163 #(.WIDTH(4)) u_lo (
    .CLK(clk), .RST(rst), .CLR_N(clr_n), .LOAD_N(load_n),
    .ENP(enp), .ENT(ent), .D(d), .Q(q_lo), .RCO(rco_lo)
  );

  counter_74x163 #(.WIDTH(4)) u_hi (
    .CLK(clk), .RST(rst), .CLR_N(clr_n), .LOAD_N(load_n),
    .ENP(enp), .ENT(rco_lo), .D(d_hi), .Q(q_hi), .RCO(rco_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic p, input logic t,
                       input logic [3:0] dv);
    clr_n  = c;
    load_n = l;
    enp    = p;
    ent    = t;
    d      = dv;
  endtask

  initial begin
    rst  = 1'b1;
    d_hi = 4'd0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    step();
    check("reset_q", q_lo, 0);
    check("reset_rco", rco_lo, 0);
    check("reset_q_hi", q_hi, 0);

`ifndef COUNTER_74X163_SYNC_EN
    // fields: clr_n load_n enp ent d | exp_q exp_rco
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd1,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd2,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd3,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 4'd14, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd15, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  4'd15, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  4'd15, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  4'd0,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4'd5,  4'd5,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  4'd6,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  4'd3,  1'b0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 4'd3, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd7,  4'd0,  1'b0});

    // Load 9, then reset overrides an active count request
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    step();
    check("load9_q", q_lo, 9);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    step();
    check("rst_from9_q", q_lo, 0);
    check("rst_from9_rco", rco_lo, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr_n, vecs[i].load_n, vecs[i].enp, vecs[i].ent, vecs[i].d);
      step();
      check($sformatf("vec%0d_q", i), q_lo, vecs[i].exp_q);
      check($sformatf("vec%0d_rco", i), rco_lo, vecs[i].exp_rco);
    end

    // Reset in the middle of counting aborts the count
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    step();
    step();
    check("midcount_q", q_lo, 2);
    rst = 1'b1;
    step();
    check("midcount_rst_q", q_lo, 0);
    rst = 1'b0;
    step();
    check("after_rst_q", q_lo, 1);

    // Cascade: 300 counts from zero across two 4-bit stages
    rst = 1'b1;
    step();
    check("casc_rst", {q_hi, q_lo}, 0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 300; i++) step();
    check("cascade_300", {q_hi, q_lo}, 44);
    check("cascade_rco_lo", rco_lo, 0);
`else
    // Synchronized build: flush inactive controls, then a load takes three edges
    rst = 1'b0;
    step();
    step();
    check("sync_idle_q", q_lo, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd12);
    step();
    check("sync_edge_k_q", q_lo, 0);
    load_n = 1'b1;
    step();
    check("sync_edge_k1_q", q_lo, 0);
    step();
    check("sync_edge_k2_q", q_lo, 12);
    step();
    check("sync_hold_q", q_lo, 12);
    check("sync_rco", rco_lo, 0);
    ent = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    step();
    step();
    check("sync_ent_lag_rco", rco_lo, 0);
    step();
    check("sync_load15_q", q_lo, 15);
    check("sync_load15_rco", rco_lo, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_74x163.md
COUNTER_74X163 -- requirements
Module: counter_74x163

Interface
REQ-001 SHALL have parameter: WIDTH, 4, counter width in bits (legal 1..16).
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: CLR_N  input  1  synchronous clear, active-low.
REQ-005 SHALL have port: LOAD_N  input  1  synchronous parallel load, active-low.
REQ-006 SHALL have port: ENP  input  1  count enable P, active-high.
REQ-007 SHALL have port: ENT  input  1  count enable T / cascade enable, active-high.
REQ-008 SHALL have port: D  input  WIDTH  parallel load data.
REQ-009 SHALL have port: Q  output  WIDTH  registered count.
REQ-010 SHALL have port: RCO  output  1  ripple carry out for cascading.

Function
REQ-011 SHALL use effective controls: raw CLR_N/LOAD_N/ENP/ENT, or their synchronized copies per REQ-024.
REQ-012 SHALL apply one action per rising edge, priority: RST > CLR_N low > LOAD_N low > (ENP & ENT) count > hold.
REQ-013 SHALL set Q to 0 on edge with CLR_N low, regardless of LOAD_N, ENP, ENT, D.
REQ-014 SHALL set Q to D on edge with CLR_N high, LOAD_N low, regardless of ENP/ENT.
REQ-015 SHALL increment Q by 1 modulo 2^WIDTH when CLR_N, LOAD_N high and ENP, ENT both high.
REQ-016 SHALL wrap Q from 2^WIDTH-1 to 0 on count; no saturation, no sticky flag.
REQ-017 SHALL hold Q when CLR_N, LOAD_N high and ENP or ENT low.
REQ-018 SHALL drive RCO combinationally = effective ENT AND (Q == 2^WIDTH-1); ENP does not affect RCO.
REQ-019 SHALL make Q change exactly one cycle after the qualifying edge sample (latency 1 from effective controls).
REQ-020 SHALL support cascading: RCO of stage n to ENT of stage n+1, shared CLK, yields 2*WIDTH-bit binary count.

Reset
REQ-021 SHALL, on edge with RST high, set Q to 0 and override every other input.
REQ-022 SHALL, on reset, load synchronizer stages with inactive values: CLR_N=1, LOAD_N=1, ENP=0, ENT=0.
REQ-023 SHALL resume normal operation on first edge after RST deasserts; reset mid-count aborts count, no partial update.

Configuration
REQ-024 SHALL, with macro COUNTER_74X163_SYNC_EN defined, pass CLR_N, LOAD_N, ENP, ENT through 2-flop synchronizers; D sampled directly; control-to-Q latency becomes 3 edges.
REQ-025 SHALL, with COUNTER_74X163_SYNC_EN undefined, use raw inputs directly; no synchronizer flops present.
REQ-026 SHALL keep RCO derived from effective (synchronized when enabled) ENT in both builds.

Verification (raw build unless noted; WIDTH=4)
REQ-027 SHALL verify: RST high 1 edge with Q=9 -> Q=0, RCO=0; ENP=ENT=1 thereafter -> Q=1,2,3 on successive edges.
REQ-028 SHALL verify: Q=14, ENP=ENT=1 -> Q=15 with RCO=1, next edge Q=0 with RCO=0; ENT=0 at Q=15 -> RCO=0, Q holds.
REQ-029 SHALL verify: CLR_N=0, LOAD_N=0, D=5, ENP=ENT=1 same edge -> Q=0; then CLR_N=1 -> Q=5; then LOAD_N=1 -> Q=6.
REQ-030 SHALL verify: two instances cascaded via RCO->ENT, 300 count edges from 0 -> combined {Q_hi,Q_lo}=300 mod 256=44.
REQ-031 SHALL verify: ENP=1, ENT=0 for 5 edges from Q=3 -> Q stays 3; ENP=0, ENT=1 at Q=15 -> RCO=1, Q holds.
REQ-032 SHALL verify (COUNTER_74X163_SYNC_EN): LOAD_N low with D=12 sampled at edge k -> Q=12 after edge k+2, unchanged through k+1.
